// File: rtl/cplx_conj_frame_sched.sv
// Frame-aware complex conjugation scheduler for an I/Q stream.
// Per-frame conjugate/bypass decision at sof; config changes apply only on frame boundaries.
module cplx_conj_frame_sched #(
  parameter int unsigned DATA_SIZE   = 16,
  parameter int unsigned PERIOD_SIZE = 8
) (
  input  logic                   data_clk_i,
  input  logic                   data_rst_i,
  input  logic [DATA_SIZE-1:0]   data_i_i,
  input  logic [DATA_SIZE-1:0]   data_q_i,
  input  logic                   data_en_i,
  input  logic                   data_sof_i,
  input  logic                   data_eof_i,
  input  logic [1:0]             cfg_mode_i,
  input  logic [PERIOD_SIZE-1:0] cfg_period_i,
  input  logic                   cfg_update_i,
  output logic [DATA_SIZE-1:0]   data_i_o,
  output logic [DATA_SIZE-1:0]   data_q_o,
  output logic                   data_en_o,
  output logic                   data_sof_o,
  output logic                   data_eof_o,
  output logic                   data_rst_o,
  output logic                   data_clk_o,
  output logic                   cfg_pending_o,
  output logic                   conj_active_o,
  output logic                   frame_err_o
);

  typedef enum logic [0:0] {StIdle, StInFrame} state_e;

  localparam logic [DATA_SIZE-1:0] QMin = {1'b1, {(DATA_SIZE-1){1'b0}}};
  localparam logic [DATA_SIZE-1:0] QMax = {1'b0, {(DATA_SIZE-1){1'b1}}};

  state_e                 state_q, state_d;
  logic [1:0]             mode_q, mode_d, pend_mode_q, pend_mode_d;
  logic [PERIOD_SIZE-1:0] period_q, period_d, pend_period_q, pend_period_d;
  logic [PERIOD_SIZE-1:0] phase_q, phase_d;
  logic                   cfg_pending_q, cfg_pending_d;
  logic                   frame_conj_q, frame_conj_d;
  logic [DATA_SIZE-1:0]   data_i_q, data_i_d, data_q_q, data_q_d;
  logic                   data_en_q, data_en_d, data_sof_q, data_sof_d, data_eof_q, data_eof_d;
  logic                   conj_active_q, conj_active_d, frame_err_q, frame_err_d;

  logic                   sof_acc, eof_acc, apply, decision, conj, err;
  logic [1:0]             eff_mode;
  logic [PERIOD_SIZE-1:0] eff_period, eff_phase;
  logic [DATA_SIZE-1:0]   q_neg;

  always_comb begin
    sof_acc = data_en_i & data_sof_i;
    eof_acc = data_en_i & data_eof_i;
    // Pending config lands at an accepted sof, or on any idle cycle without one.
    apply   = cfg_pending_q & (sof_acc | (state_q == StIdle));

    eff_mode   = apply ? pend_mode_q   : mode_q;
    eff_period = apply ? pend_period_q : period_q;
    eff_phase  = apply ? '0            : phase_q;

    case (eff_mode)
      2'd1:    decision = 1'b1;
      2'd2:    decision = (eff_phase == '0);
      default: decision = 1'b0;
    endcase

    state_d       = state_q;
    mode_d        = mode_q;
    period_d      = period_q;
    phase_d       = phase_q;
    pend_mode_d   = pend_mode_q;
    pend_period_d = pend_period_q;
    cfg_pending_d = cfg_pending_q;
    frame_conj_d  = frame_conj_q;
    conj          = 1'b0;
    err           = 1'b0;

    if (apply) begin
      mode_d        = pend_mode_q;
      period_d      = pend_period_q;
      phase_d       = '0;
      cfg_pending_d = 1'b0;
    end
    // An update in the apply cycle refills pending and keeps the flag raised.
    if (cfg_update_i) begin
      pend_mode_d   = cfg_mode_i;
      pend_period_d = cfg_period_i;
      cfg_pending_d = 1'b1;
    end

    if (sof_acc) begin
      conj         = decision;
      frame_conj_d = decision;
      err          = (state_q == StInFrame);
      state_d      = eof_acc ? StIdle : StInFrame;
      if (eff_mode == 2'd2) begin
        phase_d = (eff_phase == eff_period) ? '0 : eff_phase + PERIOD_SIZE'(1);
      end
    end else if (data_en_i) begin
      if (state_q == StInFrame) begin
        conj = frame_conj_q;
        if (eof_acc) state_d = StIdle;
      end else begin
        err = 1'b1;
      end
    end

    q_neg         = (data_q_i == QMin) ? QMax : ('0 - data_q_i);
    data_i_d      = data_i_i;
    data_q_d      = conj ? q_neg : data_q_i;
    data_en_d     = data_en_i;
    data_sof_d    = data_sof_i;
    data_eof_d    = data_eof_i;
    conj_active_d = conj;
    frame_err_d   = err;
  end

  always_ff @(posedge data_clk_i) begin
    if (data_rst_i) begin
      state_q       <= StIdle;
      mode_q        <= '0;
      period_q      <= '0;
      phase_q       <= '0;
      pend_mode_q   <= '0;
      pend_period_q <= '0;
      cfg_pending_q <= 1'b0;
      frame_conj_q  <= 1'b0;
      data_i_q      <= '0;
      data_q_q      <= '0;
      data_en_q     <= 1'b0;
      data_sof_q    <= 1'b0;
      data_eof_q    <= 1'b0;
      conj_active_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      period_q      <= period_d;
      phase_q       <= phase_d;
      pend_mode_q   <= pend_mode_d;
      pend_period_q <= pend_period_d;
      cfg_pending_q <= cfg_pending_d;
      frame_conj_q  <= frame_conj_d;
      data_i_q      <= data_i_d;
      data_q_q      <= data_q_d;
      data_en_q     <= data_en_d;
      data_sof_q    <= data_sof_d;
      data_eof_q    <= data_eof_d;
      conj_active_q <= conj_active_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign data_i_o      = data_i_q;
  assign data_q_o      = data_q_q;
  assign data_en_o     = data_en_q;
  assign data_sof_o    = data_sof_q;
  assign data_eof_o    = data_eof_q;
  assign cfg_pending_o = cfg_pending_q;
  assign conj_active_o = conj_active_q;
  assign frame_err_o   = frame_err_q;
  assign data_rst_o    = data_rst_i;
  assign data_clk_o    = data_clk_i;

endmodule

// File: tb/tb_cplx_conj_frame_sched.sv
// Directed self-checking bench for cplx_conj_frame_sched.
module tb_cplx_conj_frame_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] di, dq;
  logic        en, sof, eof;
  logic [1:0]  mode;
  logic [7:0]  period;
  logic        upd;
  logic [15:0] oi, oq;
  logic        oen, osof, oeof, orst, oclk, opend, oconj, oerr;

  int tests = 0;
  int fails = 0;

  cplx_conj_frame_sched #(.DATA_SIZE(16), .PERIOD_SIZE(8)) dut (
    .data_clk_i(clk), .data_rst_i(rst), .data_i_i(di), .data_q_i(dq),
    .data_en_i(en), .data_sof_i(sof), .data_eof_i(eof),
    .cfg_mode_i(mode), .cfg_period_i(period), .cfg_update_i(upd),
    .data_i_o(oi), .data_q_o(oq), .data_en_o(oen), .data_sof_o(osof), .data_eof_o(oeof),
    .data_rst_o(orst), .data_clk_o(oclk), .cfg_pending_o(opend),
    .conj_active_o(oconj), .frame_err_o(oerr)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, then sample just after the capturing edge.
  task automatic drive(input logic e, input logic s, input logic f,
                       input logic [15:0] i, input logic [15:0] q, input logic u);
    @(negedge clk);
    en = e; sof = s; eof = f; di = i; dq = q; upd = u;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [1:0] m, input logic [7:0] p);
    mode = m; period = p;
    drive(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b1);
    tests++;
    if (opend !== 1'b1) begin
      $display("FAIL set_cfg_pending got=%b exp=1", opend); fails++;
    end
    drive(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
    tests++;
    if (opend !== 1'b0) begin
      $display("FAIL set_cfg_applied got=%b exp=0", opend); fails++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 16'h1234, 16'h5678, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 16'h1234, 16'h5678, 1'b0);
    tests++;
    if ({oi, oq, oen, osof, oeof, opend, oconj, oerr} !== 38'd0) begin
      $display("FAIL reset_outputs got i=%h q=%h en=%b sof=%b eof=%b pend=%b conj=%b err=%b exp all 0",
               oi, oq, oen, osof, oeof, opend, oconj, oerr);
      fails++;
    end
    tests++;
    if (orst !== 1'b1) begin
      $display("FAIL reset_passthrough got=%b exp=1", orst); fails++;
    end
    rst = 1'b0;
    #1;
    tests++;
    if (orst !== 1'b0) begin
      $display("FAIL reset_release got=%b exp=0", orst); fails++;
    end
  endtask

  task automatic test_conj_mode1();
    logic [15:0] qin [4];
    logic [15:0] qexp[4];
    qin  = '{16'd100, 16'hFFFB, 16'd0, 16'h8000};
    qexp = '{16'hFF9C, 16'd5, 16'd0, 16'h7FFF};
    set_cfg(2'd1, 8'd0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, k == 0, k == 3, 16'(k + 1), qin[k], 1'b0);
      tests++;
      if (oq !== qexp[k] || oi !== 16'(k + 1) || oconj !== 1'b1 || oerr !== 1'b0 ||
          oen !== 1'b1 || osof !== (k == 0) || oeof !== (k == 3)) begin
        $display("FAIL mode1_s%0d got i=%h q=%h conj=%b err=%b sof=%b eof=%b exp i=%h q=%h conj=1",
                 k, oi, oq, oconj, oerr, osof, oeof, 16'(k + 1), qexp[k]);
        fails++;
      end
    end
  endtask

  task automatic test_periodic();
    logic pat[6];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    set_cfg(2'd2, 8'd2);
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < 2; k++) begin
        drive(1'b1, k == 0, k == 1, 16'd9, 16'd50, 1'b0);
        tests++;
        if (oconj !== pat[f] || oq !== (pat[f] ? 16'hFFCE : 16'd50) || oi !== 16'd9) begin
          $display("FAIL periodic_f%0d_s%0d got q=%h conj=%b exp q=%h conj=%b",
                   f, k, oq, oconj, pat[f] ? 16'hFFCE : 16'd50, pat[f]);
          fails++;
        end
      end
    end
  endtask

  task automatic test_cfg_mid_frame();
    set_cfg(2'd0, 8'd0);
    mode = 2'd1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, k == 0, k == 3, 16'd1, 16'd7, k == 1);
      tests++;
      if (oconj !== 1'b0 || oq !== 16'd7 || opend !== (k >= 1)) begin
        $display("FAIL midcfg_s%0d got q=%h conj=%b pend=%b exp q=0007 conj=0 pend=%b",
                 k, oq, oconj, opend, k >= 1);
        fails++;
      end
    end
    drive(1'b1, 1'b1, 1'b0, 16'd1, 16'd7, 1'b0);
    tests++;
    if (oconj !== 1'b1 || oq !== 16'hFFF9 || opend !== 1'b0) begin
      $display("FAIL midcfg_next_sof got q=%h conj=%b pend=%b exp q=fff9 conj=1 pend=0",
               oq, oconj, opend);
      fails++;
    end
    drive(1'b1, 1'b0, 1'b1, 16'd1, 16'd7, 1'b0);
    tests++;
    if (oconj !== 1'b1 || oq !== 16'hFFF9) begin
      $display("FAIL midcfg_next_eof got q=%h conj=%b exp q=fff9 conj=1", oq, oconj);
      fails++;
    end
  endtask

  task automatic test_sof_err();
    drive(1'b1, 1'b1, 1'b0, 16'd0, 16'd10, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 16'd0, 16'd10, 1'b0);
    tests++;
    if (oerr !== 1'b0) begin
      $display("FAIL sof_err_pre got=%b exp=0", oerr); fails++;
    end
    drive(1'b1, 1'b1, 1'b0, 16'd0, 16'd20, 1'b0);
    tests++;
    if (oerr !== 1'b1 || oconj !== 1'b1 || oq !== 16'hFFEC) begin
      $display("FAIL sof_err_second got err=%b conj=%b q=%h exp err=1 conj=1 q=ffec",
               oerr, oconj, oq);
      fails++;
    end
    drive(1'b1, 1'b0, 1'b1, 16'd0, 16'd20, 1'b0);
    tests++;
    if (oerr !== 1'b0 || oconj !== 1'b1) begin
      $display("FAIL sof_err_single_pulse got err=%b conj=%b exp err=0 conj=1", oerr, oconj);
      fails++;
    end
  endtask

  task automatic test_single_sample();
    drive(1'b1, 1'b1, 1'b1, 16'd4, 16'hFFFD, 1'b0);
    tests++;
    if (oq !== 16'd3 || oconj !== 1'b1 || oerr !== 1'b0 || oi !== 16'd4) begin
      $display("FAIL single_sample got q=%h conj=%b err=%b exp q=0003 conj=1 err=0",
               oq, oconj, oerr);
      fails++;
    end
    // Stray sample right after: FSM must be idle, so bypassed with error.
    drive(1'b1, 1'b0, 1'b0, 16'd4, 16'hFFFD, 1'b0);
    tests++;
    if (oq !== 16'hFFFD || oconj !== 1'b0 || oerr !== 1'b1) begin
      $display("FAIL single_then_stray got q=%h conj=%b err=%b exp q=fffd conj=0 err=1",
               oq, oconj, oerr);
      fails++;
    end
  endtask

  task automatic test_reset_mid_frame();
    drive(1'b1, 1'b1, 1'b0, 16'd2, 16'd9, 1'b0);
    tests++;
    if (oconj !== 1'b1) begin
      $display("FAIL rstmid_pre got conj=%b exp=1", oconj); fails++;
    end
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 16'd2, 16'd9, 1'b0);
    tests++;
    if ({oi, oq, oen, osof, oeof, opend, oconj, oerr} !== 38'd0) begin
      $display("FAIL rstmid_outputs got i=%h q=%h en=%b eof=%b conj=%b exp all 0",
               oi, oq, oen, oeof, oconj);
      fails++;
    end
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 16'd2, 16'd9, 1'b0);
    tests++;
    if (oconj !== 1'b0 || oq !== 16'd9 || oerr !== 1'b0) begin
      $display("FAIL rstmid_bypass got q=%h conj=%b err=%b exp q=0009 conj=0 err=0",
               oq, oconj, oerr);
      fails++;
    end
    drive(1'b1, 1'b0, 1'b1, 16'd2, 16'd9, 1'b0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sof = 1'b0; eof = 1'b0; di = '0; dq = '0;
    mode = '0; period = '0; upd = 1'b0;
    test_reset();
    test_conj_mode1();
    test_periodic();
    test_cfg_mid_frame();
    test_sof_err();
    test_single_sample();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
